// File: rtl/lc3_control_fsm_if.sv
// Control bundle between the LC-3 sequencer and its datapath.
// master = sequencer side (drives controls), slave = datapath side.
interface lc3_control_fsm_if #(
    parameter int STATE_W = 5
);
    logic [15:0]        ir;
    logic [2:0]         nzp;
    logic               mem_ready;

    logic               LDIR, LDPC, LDMAR, LDMDR, LDREG, LDCC;
    logic [1:0]         PCMUXsel;
    logic               ADDR1sel;
    logic [1:0]         ADDR2sel;
    logic               MARMUXsel;
    logic               PCENA, MARMUXENA, MDRENA, ALUENA;
    logic [1:0]         ALUK;
    logic               DRsel, SR1sel, MIOsel;
    logic               mem_en, mem_we;
    logic               halted, illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  ir, nzp, mem_ready,
        output LDIR, LDPC, LDMAR, LDMDR, LDREG, LDCC,
               PCMUXsel, ADDR1sel, ADDR2sel, MARMUXsel,
               PCENA, MARMUXENA, MDRENA, ALUENA, ALUK,
               DRsel, SR1sel, MIOsel, mem_en, mem_we,
               halted, illegal, state
    );

    modport slave (
        output ir, nzp, mem_ready,
        input  LDIR, LDPC, LDMAR, LDMDR, LDREG, LDCC,
               PCMUXsel, ADDR1sel, ADDR2sel, MARMUXsel,
               PCENA, MARMUXENA, MDRENA, ALUENA, ALUK,
               DRsel, SR1sel, MIOsel, mem_en, mem_we,
               halted, illegal, state
    );
endinterface

// File: rtl/lc3_control_fsm.sv
// LC-3 Moore control sequencer: fetch/decode/execute for every opcode but RTI.
// Controls decode from the state register; BR, JSR2 and the memory wait
// states additionally look at ir/nzp/mem_ready. HALT and ILL are terminal,
// which makes halted/illegal sticky until reset.
module lc3_control_fsm #(
    parameter int         STATE_W  = 5,
    parameter logic [7:0] HALT_VEC = 8'h25
) (
    input logic               clk,
    input logic               rst,
    lc3_control_fsm_if.master bus
);
    typedef enum logic [4:0] {
        S_F1, S_F2, S_F3, S_DEC, S_ALU, S_BR, S_JMP, S_JSR1, S_JSR2, S_LEA,
        S_AD, S_RD, S_IND, S_RD2, S_WB, S_SD, S_WR,
        S_TR1, S_TR2, S_TR3, S_TR4, S_HALT, S_ILL
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                           OP_ST  = 4'b0011, OP_JSR = 4'b0100, OP_AND = 4'b0101,
                           OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
                           OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                           OP_LEA = 4'b1110, OP_TRP = 4'b1111;

    typedef struct packed {
        logic       ldir, ldpc, ldmar, ldmdr, ldreg, ldcc;
        logic [1:0] pcmux;
        logic       addr1;
        logic [1:0] addr2;
        logic       marmux;
        logic       pcena, marmuxena, mdrena, aluena;
        logic [1:0] aluk;
        logic       drsel, sr1sel, miosel;
        logic       mem_en, mem_we;
        logic       halted, illegal;
    } ctrl_t;

    state_t     st;
    ctrl_t      c;
    logic [3:0] op;
    logic       unused_ir8;

    assign op         = bus.ir[15:12];
    assign unused_ir8 = bus.ir[8];

    // State sequencing; ir is stable from DEC until the next fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= S_F1;
        end else begin
            case (st)
                S_F1:  st <= S_F2;
                S_F2:  if (bus.mem_ready) st <= S_F3;
                S_F3:  st <= S_DEC;
                S_DEC: begin
                    case (op)
                        OP_ADD, OP_AND, OP_NOT:                 st <= S_ALU;
                        OP_BR:                                  st <= S_BR;
                        OP_JMP:                                 st <= S_JMP;
                        OP_JSR:                                 st <= S_JSR1;
                        OP_LEA:                                 st <= S_LEA;
                        OP_LD, OP_ST, OP_LDR, OP_STR,
                        OP_LDI, OP_STI:                         st <= S_AD;
                        OP_TRP: st <= (bus.ir[7:0] == HALT_VEC) ? S_HALT : S_TR1;
                        default:                                st <= S_ILL;
                    endcase
                end
                S_ALU, S_BR, S_JMP, S_JSR2, S_LEA, S_WB, S_TR4: st <= S_F1;
                S_JSR1: st <= S_JSR2;
                S_AD:   st <= (op == OP_ST || op == OP_STR) ? S_SD : S_RD;
                S_RD:   if (bus.mem_ready)
                            st <= (op == OP_LDI || op == OP_STI) ? S_IND : S_WB;
                S_IND:  st <= (op == OP_STI) ? S_SD : S_RD2;
                S_RD2:  if (bus.mem_ready) st <= S_WB;
                S_SD:   st <= S_WR;
                S_WR:   if (bus.mem_ready) st <= S_F1;
                S_TR1:  st <= S_TR2;
                S_TR2:  st <= S_TR3;
                S_TR3:  if (bus.mem_ready) st <= S_TR4;
                S_HALT: st <= S_HALT;
                S_ILL:  st <= S_ILL;
                default: st <= S_F1;
            endcase
        end
    end

    // Control decode per state; everything forced low while reset is held.
    always_comb begin
        c = '0;
        case (st)
            S_F1:  begin c.pcena = 1'b1; c.ldmar = 1'b1; c.ldpc = 1'b1; end
            S_F2, S_RD, S_RD2, S_TR3: begin
                c.mem_en = 1'b1;
                c.ldmdr  = bus.mem_ready;
            end
            S_F3:  begin c.mdrena = 1'b1; c.ldir = 1'b1; end
            S_ALU: begin
                c.aluena = 1'b1; c.ldreg = 1'b1; c.ldcc = 1'b1;
                c.aluk   = (op == OP_AND) ? 2'd1 : (op == OP_NOT) ? 2'd2 : 2'd0;
            end
            S_BR: if (|(bus.ir[11:9] & bus.nzp)) begin
                c.ldpc = 1'b1; c.pcmux = 2'd2; c.addr2 = 2'd2;
            end
            S_JMP: begin c.addr1 = 1'b1; c.pcmux = 2'd2; c.ldpc = 1'b1; end
            S_JSR1: begin c.pcena = 1'b1; c.ldreg = 1'b1; c.drsel = 1'b1; end
            S_JSR2: begin
                c.ldpc = 1'b1; c.pcmux = 2'd2;
                if (bus.ir[11]) c.addr2 = 2'd3;
                else            c.addr1 = 1'b1;
            end
            S_LEA: begin
                c.marmux = 1'b1; c.addr2 = 2'd2; c.marmuxena = 1'b1; c.ldreg = 1'b1;
            end
            S_AD: begin
                c.marmuxena = 1'b1; c.ldmar = 1'b1; c.marmux = 1'b1;
                if (op == OP_LDR || op == OP_STR) begin
                    c.addr1 = 1'b1; c.addr2 = 2'd1;
                end else begin
                    c.addr2 = 2'd2;
                end
            end
            S_WB:  begin c.mdrena = 1'b1; c.ldreg = 1'b1; c.ldcc = 1'b1; end
            S_IND: begin c.mdrena = 1'b1; c.ldmar = 1'b1; end
            S_SD: begin
                c.aluk = 2'd3; c.sr1sel = 1'b1; c.aluena = 1'b1;
                c.ldmdr = 1'b1; c.miosel = 1'b1;
            end
            S_WR:  begin c.mem_en = 1'b1; c.mem_we = 1'b1; end
            S_TR1: begin c.marmuxena = 1'b1; c.ldmar = 1'b1; end
            S_TR2: begin c.pcena = 1'b1; c.ldreg = 1'b1; c.drsel = 1'b1; end
            S_TR4: begin c.mdrena = 1'b1; c.pcmux = 2'd1; c.ldpc = 1'b1; end
            S_HALT: c.halted  = 1'b1;
            S_ILL:  c.illegal = 1'b1;
            default: c = '0;
        endcase
        if (rst) c = '0;
    end

    assign bus.LDIR      = c.ldir;
    assign bus.LDPC      = c.ldpc;
    assign bus.LDMAR     = c.ldmar;
    assign bus.LDMDR     = c.ldmdr;
    assign bus.LDREG     = c.ldreg;
    assign bus.LDCC      = c.ldcc;
    assign bus.PCMUXsel  = c.pcmux;
    assign bus.ADDR1sel  = c.addr1;
    assign bus.ADDR2sel  = c.addr2;
    assign bus.MARMUXsel = c.marmux;
    assign bus.PCENA     = c.pcena;
    assign bus.MARMUXENA = c.marmuxena;
    assign bus.MDRENA    = c.mdrena;
    assign bus.ALUENA    = c.aluena;
    assign bus.ALUK      = c.aluk;
    assign bus.DRsel     = c.drsel;
    assign bus.SR1sel    = c.sr1sel;
    assign bus.MIOsel    = c.miosel;
    assign bus.mem_en    = c.mem_en;
    assign bus.mem_we    = c.mem_we;
    assign bus.halted    = c.halted;
    assign bus.illegal   = c.illegal;
    assign bus.state     = rst ? '0 : STATE_W'(st);
endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: each instruction pushes its expected
// per-cycle control trace into a queue, which is popped and checked cycle by cycle.
module tb_lc3_control_fsm;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [4:0] f1_state;

    lc3_control_fsm_if #(.STATE_W(5)) b();

    lc3_control_fsm #(.STATE_W(5), .HALT_VEC(8'h25)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    // Observed control vector, fixed bit order used by the expectation helpers.
    logic [24:0] obs;
    logic        gates_ok;
    assign obs = {b.LDIR, b.LDPC, b.LDMAR, b.LDMDR, b.LDREG, b.LDCC,
                  b.PCMUXsel, b.ADDR1sel, b.ADDR2sel, b.MARMUXsel,
                  b.PCENA, b.MARMUXENA, b.MDRENA, b.ALUENA, b.ALUK,
                  b.DRsel, b.SR1sel, b.MIOsel, b.mem_en, b.mem_we,
                  b.halted, b.illegal};
    assign gates_ok = ($countones({b.PCENA, b.MARMUXENA, b.MDRENA, b.ALUENA}) <= 1);

    localparam logic [24:0] LDIR = 25'd1 << 24, LDPC = 25'd1 << 23, LDMAR = 25'd1 << 22,
                            LDMDR = 25'd1 << 21, LDREG = 25'd1 << 20, LDCC = 25'd1 << 19,
                            A1 = 25'd1 << 16, MMX = 25'd1 << 13, PCENA = 25'd1 << 12,
                            MMXENA = 25'd1 << 11, MDRENA = 25'd1 << 10, ALUENA = 25'd1 << 9,
                            DR7 = 25'd1 << 6, SR1 = 25'd1 << 5, MIO = 25'd1 << 4,
                            MEN = 25'd1 << 3, MWE = 25'd1 << 2, HLT = 25'd1 << 1, ILL = 25'd1;

    function automatic logic [24:0] pcm(input int v); return 25'(v) << 17; endfunction
    function automatic logic [24:0] a2(input int v);  return 25'(v) << 14; endfunction
    function automatic logic [24:0] ak(input int v);  return 25'(v) << 7;  endfunction

    typedef struct {
        string       tag;
        logic        rdy;
        logic [24:0] exp;
    } ent_t;
    ent_t q[$];

    task automatic push(input string tag, input logic rdy, input logic [24:0] exp);
        ent_t e;
        e.tag = tag; e.rdy = rdy; e.exp = exp;
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic fetch();
        push("F1", 1'b1, LDMAR | LDPC | PCENA);
        push("F2", 1'b1, MEN | LDMDR);
        push("F3", 1'b1, MDRENA | LDIR);
        push("DEC", 1'b1, '0);
    endtask

    // Entered at a falling edge; each entry is one clock cycle.
    task automatic run();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            b.mem_ready = e.rdy;
            #1;
            chk(e.tag, obs, e.exp);
            chk({e.tag, "/gates"}, 25'(gates_ok), 25'd1);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst/outs", obs, '0);
        chk("rst/state", 25'(b.state), '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; b.ir = '0; b.nzp = '0; b.mem_ready = 1'b0;
        @(negedge clk);
        do_reset();
        #1 f1_state = b.state;

        b.ir = 16'h1261;
        fetch(); push("ADD", 1'b1, ALUENA | LDREG | LDCC | ak(0));
        run();

        b.ir = 16'h0405; b.nzp = 3'b010;
        fetch(); push("BRz/taken", 1'b1, LDPC | pcm(2) | a2(2));
        run();
        b.nzp = 3'b100;
        fetch(); push("BRz/not", 1'b1, '0);
        run();

        b.ir = 16'h2202;
        fetch();
        push("LD/AD", 1'b1, MMXENA | LDMAR | MMX | a2(2));
        for (int i = 0; i < 3; i++) push("LD/RDwait", 1'b0, MEN);
        push("LD/RDrdy", 1'b1, MEN | LDMDR);
        push("LD/WB", 1'b1, MDRENA | LDREG | LDCC);
        run();

        b.ir = 16'hB005;
        fetch();
        push("STI/AD", 1'b1, MMXENA | LDMAR | MMX | a2(2));
        push("STI/RD", 1'b1, MEN | LDMDR);
        push("STI/IND", 1'b1, MDRENA | LDMAR);
        push("STI/SD", 1'b1, ak(3) | SR1 | ALUENA | LDMDR | MIO);
        push("STI/WR", 1'b1, MEN | MWE);
        run();

        b.ir = 16'hF023;
        fetch();
        push("TRAP/TR1", 1'b1, MMXENA | LDMAR);
        push("TRAP/TR2", 1'b1, PCENA | LDREG | DR7);
        push("TRAP/TR3", 1'b1, MEN | LDMDR);
        push("TRAP/TR4", 1'b1, MDRENA | pcm(1) | LDPC);
        run();

        b.ir = 16'hF025;
        fetch();
        for (int i = 0; i < 3; i++) push("HALT", 1'b1, HLT);
        run();

        do_reset();
        b.ir = 16'h8000;
        fetch();
        for (int i = 0; i < 2; i++) push("ILL", 1'b1, ILL);
        run();

        do_reset();
        b.ir = 16'h3005;
        fetch();
        push("ST/AD", 1'b1, MMXENA | LDMAR | MMX | a2(2));
        push("ST/SD", 1'b1, ak(3) | SR1 | ALUENA | LDMDR | MIO);
        push("ST/WRwait", 1'b0, MEN | MWE);
        push("ST/WRwait", 1'b0, MEN | MWE);
        run();
        // Still waiting in WR: abort the write with a one-cycle reset pulse.
        b.mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort/mem", 25'({b.mem_en, b.mem_we}), 25'd0);
        chk("abort/outs", obs, '0);
        rst = 1'b0;
        #1;
        chk("abort/F1", obs, LDMAR | LDPC | PCENA);
        chk("abort/state", 25'(b.state), 25'(f1_state));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
